iq_comp_param: RTL and testbench
================================

Name: iq_comp_param

Overview:
- Parametrised successor to the fixed 4-bit iq_comp.
- Blind adaptive I/Q imbalance compensator for the 16 MHz receive path: y = x + w·conj(x).
- Weight update is LMS-style, w ← w − µ·y².
- New versus iq_comp: generic data and weight widths, an input valid strobe with a matching output valid, a fourth operating mode (adapt from preset), and a programmable settle detector.

Parameters:
- DATA_W, 4: width of Ix/Qx/Iy/Qy.
- W_W, 13: width of the signed weights Wr/Wj.
- W_FRAC, 12: fractional bits of the weights.
- MU_SHIFT, 4: step size µ = 2^-MU_SHIFT, applied as an arithmetic right shift.
- SETTLE_TOL, 0: maximum |Δweight| that counts as a "quiet" update.
- SETTLE_LEN, 64: number of consecutive quiet updates required to assert settled.

Ports:
- clk, in, 1: 16 MHz sample clock.
- RESET, in, 1: synchronous, active-high reset.
- in_valid, in, 1: Ix/Qx hold a new sample this cycle.
- Ix, in, DATA_W: I sample, unsigned offset-binary.
- Qx, in, DATA_W: Q sample, unsigned offset-binary.
- freeze_iqcomp, in, 1: hold the weights and the settle counter.
- op_mode, in, 2: 00 bypass, 01 adapt from 0, 10 fixed (Wr_in/Wj_in), 11 adapt from preset.
- Wr_in, in, W_W signed: preset/fixed real weight.
- Wj_in, in, W_W signed: preset/fixed imaginary weight.
- out_valid, out, 1: Iy/Qy are valid this cycle.
- Iy, out, DATA_W signed: compensated I.
- Qy, out, DATA_W signed: compensated Q.
- settled, out, 1: adaptation has converged.
- Wr, out, W_W signed: current real weight.
- Wj, out, W_W signed: current imaginary weight.

Behaviour:
- Reset (RESET=1 at a clk edge) clears all outputs and internal state: out_valid, Iy, Qy, settled, Wr, Wj, pipeline registers and settle counter all go to 0. Reset asserted mid-stream discards any in-flight samples.
- Stage 1: on in_valid, register I = Ix with MSB inverted and Q = Qx with MSB inverted, both signed. Register the valid bit v1.
- Stage 2, combinational from the stage-1 registers and the current weights:
  - pr = (Wr·I + Wj·Q) >>> W_FRAC; pj = (Wj·I − Wr·Q) >>> W_FRAC. The shift is arithmetic (floor).
  - yi = sat(I + pr), yq = sat(Q + pj); sat clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Iy/Qy/out_valid register yi/yq/v1. Iy/Qy hold their value when v1=0.
- Latency: exactly 2 clk edges from in_valid to out_valid. Back-to-back samples are supported at 1 per clk.
- Modes:
  - 00: pr = pj = 0 (Iy/Qy equal the signed inputs). Weights hold. settled holds.
  - 01: adaptive. Weights start at their current value (0 after reset).
  - 10: Wr/Wj ← Wr_in/Wj_in every clk. No adaptation. settled = 0.
  - 11: on the first clk where op_mode becomes 11, Wr/Wj ← Wr_in/Wj_in and the settle counter clears. Adaptive thereafter.
  - Any op_mode change clears the settle counter and settled.
- Weight update occurs in modes 01/11 on a clk edge where v1=1, freeze_iqcomp=0, and it is not the preset-load cycle. The update uses the same-edge yi/yq:
  - er = yi² − yq², ej = 2·yi·yq, each 2·DATA_W+1 bits signed.
  - Wr ← satW(Wr − (er >>> MU_SHIFT)); Wj ← satW(Wj − (ej >>> MU_SHIFT)). satW clamps to W_W signed.
  - The sample at edge n therefore uses the weights updated by sample n−1.
- Settle counter, updated on each weight-update edge:
  - If |ΔWr| ≤ SETTLE_TOL and |ΔWj| ≤ SETTLE_TOL, the counter increments, saturating at SETTLE_LEN. Otherwise it clears.
  - settled = (counter == SETTLE_LEN), registered.
  - Any non-quiet update drops settled on the next clk.
- freeze_iqcomp=1: weights, counter and settled hold. Data still flows through compensation with the frozen weights.
- Simultaneous events have this priority: RESET > op_mode change/preset load > freeze > update.
- in_valid=0 cycles: no weight update. The counter holds.

Test Plan:
- Reset: drive RESET=1 for 8 clk, then 0 with in_valid=0 -> all outputs 0; out_valid stays 0.
- Bypass latency (mode 00): Ix=0xC, Qx=0x3 with in_valid pulsed at edge k -> out_valid=1 only at edge k+2 with Iy=+4, Qy=−5; Wr=Wj=0 throughout.
- Fixed mode (10): Wr_in=2048 (0.5), Wj_in=0, constant Ix=0xC, Qx=0x8 -> Iy=+6, Qy=0, Wr=2048. Then Wr_in=4095 with Ix=0xF -> Iy saturates at +7.
- Adapt (01) after reset, constant Ix=0xC, Qx=0x8, in_valid=1:
  - First output Iy=4, after which Wr=−1.
  - All later outputs Iy=3, Qy=0; Wr stays −1, Wj=0.
  - settled rises exactly 64 updates after the Wr change.
- Freeze, then mode 11: from the settled state of the adapt test, assert freeze_iqcomp and drive Ix=0xF -> weights and settled unchanged. Then switch to mode 11 with Wr_in=100 -> Wr=100 on the next clk, settled=0, adaptation resumes.
- Reset mid-stream: during continuous adaptation, pulse RESET for one clk -> the next clk shows Wr=Wj=0, out_valid=0, settled=0; the first post-reset output appears 2 clk after the next in_valid.

Source files
------------

// File: rtl/iq_comp_param_if.sv
// Sample stream bundle for iq_comp_param: offset-binary samples in, signed
// compensated samples out.
interface iq_comp_param_if #(
  parameter int DATA_W = 4
) ();
  // in_valid and out_valid are single-cycle strobes with no backpressure:
  // a sample is taken on every clk where in_valid=1, and each one produces
  // exactly one out_valid cycle two clk edges later.
  logic                     in_valid;
  logic        [DATA_W-1:0] Ix;
  logic        [DATA_W-1:0] Qx;
  logic                     out_valid;
  logic signed [DATA_W-1:0] Iy;
  logic signed [DATA_W-1:0] Qy;

  modport master (output in_valid, Ix, Qx, input out_valid, Iy, Qy);
  modport slave  (input in_valid, Ix, Qx, output out_valid, Iy, Qy);
endinterface

// File: rtl/iq_comp_param.sv
// Blind adaptive I/Q imbalance compensator, y = x + w*conj(x), with an
// LMS-style update w <- w - mu*y^2 and a programmable settle detector.
module iq_comp_param #(
  parameter int DATA_W     = 4,
  parameter int W_W        = 13,
  parameter int W_FRAC     = 12,
  parameter int MU_SHIFT   = 4,
  parameter int SETTLE_TOL = 0,
  parameter int SETTLE_LEN = 64
) (
  input  logic                  clk,
  input  logic                  RESET,
  iq_comp_param_if.slave        bus,
  input  logic                  freeze_iqcomp,
  input  logic [1:0]            op_mode,
  input  logic signed [W_W-1:0] Wr_in,
  input  logic signed [W_W-1:0] Wj_in,
  output logic                  settled,
  output logic signed [W_W-1:0] Wr,
  output logic signed [W_W-1:0] Wj
);

  localparam int PW = W_W + DATA_W + 1;
  localparam int SW = PW + 1;
  localparam int EW = 2 * DATA_W + 1;
  localparam int XW = ((W_W > EW) ? W_W : EW) + 2;
  localparam int CW = (SETTLE_LEN > 0) ? $clog2(SETTLE_LEN + 1) : 1;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ADAPT  = 2'b01;
  localparam logic [1:0] MODE_FIXED  = 2'b10;
  localparam logic [1:0] MODE_PRESET = 2'b11;

  localparam logic signed [SW-1:0] D_MAX = SW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SW-1:0] D_MIN = SW'(-(2 ** (DATA_W - 1)));
  localparam logic signed [XW-1:0] W_MAX = XW'(2 ** (W_W - 1) - 1);
  localparam logic signed [XW-1:0] W_MIN = XW'(-(2 ** (W_W - 1)));
  localparam logic signed [XW-1:0] TOL_P = XW'(SETTLE_TOL);
  localparam logic signed [XW-1:0] TOL_N = XW'(-SETTLE_TOL);
  localparam logic [CW-1:0]        LEN_C = CW'(SETTLE_LEN);

  logic signed [DATA_W-1:0] i_q, q_q, iy_q, qy_q;
  logic                     v1_q, ov_q;
  logic signed [W_W-1:0]    wr_q, wj_q, wr_d, wj_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     settled_q, settled_d;
  logic [1:0]               mode_q;

  logic signed [PW-1:0]     wr_x, wj_x, i_x, q_x, acc_r, acc_j, pr, pj;
  logic signed [SW-1:0]     sum_i, sum_q;
  logic signed [DATA_W-1:0] yi, yq;
  logic signed [EW-1:0]     yi_e, yq_e, er, ej;
  logic signed [XW-1:0]     wr_upd, wj_upd, dlt_r, dlt_j;
  logic signed [W_W-1:0]    wr_new, wj_new;
  logic                     mode_chg, preset_ld, upd_en, quiet;

  // Compensation datapath: uses the stage-1 sample and the current weights.
  always_comb begin
    wr_x  = PW'(wr_q);
    wj_x  = PW'(wj_q);
    i_x   = PW'(i_q);
    q_x   = PW'(q_q);
    acc_r = wr_x * i_x + wj_x * q_x;
    acc_j = wj_x * i_x - wr_x * q_x;
    pr    = '0;
    pj    = '0;
    if (op_mode != MODE_BYPASS) begin
      pr = acc_r >>> W_FRAC;
      pj = acc_j >>> W_FRAC;
    end
    sum_i = SW'(i_q) + SW'(pr);
    sum_q = SW'(q_q) + SW'(pj);
    if (sum_i > D_MAX)      yi = D_MAX[DATA_W-1:0];
    else if (sum_i < D_MIN) yi = D_MIN[DATA_W-1:0];
    else                    yi = sum_i[DATA_W-1:0];
    if (sum_q > D_MAX)      yq = D_MAX[DATA_W-1:0];
    else if (sum_q < D_MIN) yq = D_MIN[DATA_W-1:0];
    else                    yq = sum_q[DATA_W-1:0];
  end

  // LMS error from the same-edge output, then saturated weight candidates.
  always_comb begin
    yi_e   = EW'(yi);
    yq_e   = EW'(yq);
    er     = yi_e * yi_e - yq_e * yq_e;
    ej     = (yi_e * yq_e) <<< 1;
    wr_upd = XW'(wr_q) - XW'(er >>> MU_SHIFT);
    wj_upd = XW'(wj_q) - XW'(ej >>> MU_SHIFT);
    if (wr_upd > W_MAX)      wr_new = W_MAX[W_W-1:0];
    else if (wr_upd < W_MIN) wr_new = W_MIN[W_W-1:0];
    else                     wr_new = wr_upd[W_W-1:0];
    if (wj_upd > W_MAX)      wj_new = W_MAX[W_W-1:0];
    else if (wj_upd < W_MIN) wj_new = W_MIN[W_W-1:0];
    else                     wj_new = wj_upd[W_W-1:0];
    dlt_r = XW'(wr_new) - XW'(wr_q);
    dlt_j = XW'(wj_new) - XW'(wj_q);
    quiet = (dlt_r <= TOL_P) && (dlt_r >= TOL_N) &&
            (dlt_j <= TOL_P) && (dlt_j >= TOL_N);
  end

  // Weight and settle control; a mode change outranks freeze and update.
  always_comb begin
    mode_chg  = (op_mode != mode_q);
    preset_ld = (op_mode == MODE_PRESET) && mode_chg;
    upd_en    = v1_q && !freeze_iqcomp && !preset_ld &&
                ((op_mode == MODE_ADAPT) || (op_mode == MODE_PRESET));
    wr_d      = wr_q;
    wj_d      = wj_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    if ((op_mode == MODE_FIXED) || preset_ld) begin
      wr_d = Wr_in;
      wj_d = Wj_in;
    end else if (upd_en) begin
      wr_d = wr_new;
      wj_d = wj_new;
      if (!quiet)              cnt_d = '0;
      else if (cnt_q != LEN_C) cnt_d = cnt_q + CW'(1);
      settled_d = (cnt_d == LEN_C);
    end
    if (mode_chg || (op_mode == MODE_FIXED)) begin
      cnt_d     = '0;
      settled_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      i_q       <= '0;
      q_q       <= '0;
      v1_q      <= 1'b0;
      iy_q      <= '0;
      qy_q      <= '0;
      ov_q      <= 1'b0;
      wr_q      <= '0;
      wj_q      <= '0;
      cnt_q     <= '0;
      settled_q <= 1'b0;
      mode_q    <= MODE_BYPASS;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        i_q <= {~bus.Ix[DATA_W-1], bus.Ix[DATA_W-2:0]};
        q_q <= {~bus.Qx[DATA_W-1], bus.Qx[DATA_W-2:0]};
      end
      ov_q <= v1_q;
      if (v1_q) begin
        iy_q <= yi;
        qy_q <= yq;
      end
      wr_q      <= wr_d;
      wj_q      <= wj_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      mode_q    <= op_mode;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.Iy        = iy_q;
  assign bus.Qy        = qy_q;
  assign settled       = settled_q;
  assign Wr            = wr_q;
  assign Wj            = wj_q;

endmodule

// File: tb/tb_iq_comp_param.sv
// Directed bench for iq_comp_param: reset, bypass latency, fixed weights with
// saturation and floor rounding, adaptation to settle, freeze, preset load,
// and reset mid-stream.
module tb_iq_comp_param;

  logic               clk = 1'b0;
  logic               RESET;
  logic               freeze_iqcomp;
  logic [1:0]         op_mode;
  logic signed [12:0] Wr_in, Wj_in;
  logic               settled;
  logic signed [12:0] Wr, Wj;
  int                 checks = 0;
  int                 failures = 0;

  iq_comp_param_if #(.DATA_W(4)) bus ();

  iq_comp_param #(
    .DATA_W(4), .W_W(13), .W_FRAC(12), .MU_SHIFT(4),
    .SETTLE_TOL(0), .SETTLE_LEN(64)
  ) dut (
    .clk           (clk),
    .RESET         (RESET),
    .bus           (bus),
    .freeze_iqcomp (freeze_iqcomp),
    .op_mode       (op_mode),
    .Wr_in         (Wr_in),
    .Wj_in         (Wj_in),
    .settled       (settled),
    .Wr            (Wr),
    .Wj            (Wj)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    RESET = 1'b1; freeze_iqcomp = 1'b0; op_mode = 2'b00;
    Wr_in = '0; Wj_in = '0;
    bus.in_valid = 1'b0; bus.Ix = '0; bus.Qx = '0;

    // Reset
    repeat (8) tick();
    RESET = 1'b0;
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_iy", bus.Iy, 0);
    chk("rst_qy", bus.Qy, 0);
    chk("rst_wr", Wr, 0);
    chk("rst_wj", Wj, 0);
    chk("rst_settled", settled, 0);
    tick();
    chk("rst_out_valid_hold", bus.out_valid, 0);

    // Bypass: 0xC -> +4, 0x3 -> -5, two edges of latency
    bus.Ix = 4'hC; bus.Qx = 4'h3; bus.in_valid = 1'b1;
    tick();
    chk("byp_ov_k1", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    tick();
    chk("byp_ov_k2", bus.out_valid, 1);
    chk("byp_iy", bus.Iy, 4);
    chk("byp_qy", bus.Qy, -5);
    chk("byp_wr", Wr, 0);
    chk("byp_wj", Wj, 0);
    tick();
    chk("byp_ov_k3", bus.out_valid, 0);
    chk("byp_iy_hold", bus.Iy, 4);

    // Fixed: Wr=0.5, I=4, Q=0 -> 4 + 2 = 6
    op_mode = 2'b10; Wr_in = 13'sd2048; Wj_in = '0;
    bus.Ix = 4'hC; bus.Qx = 4'h8; bus.in_valid = 1'b1;
    tick(); tick();
    chk("fix_iy", bus.Iy, 6);
    chk("fix_qy", bus.Qy, 0);
    chk("fix_wr", Wr, 2048);
    chk("fix_settled", settled, 0);
    // 4095*7 >>> 12 = 6, 7 + 6 saturates to 7
    Wr_in = 13'sd4095; bus.Ix = 4'hF;
    tick(); tick();
    chk("fix_sat_hi", bus.Iy, 7);
    chk("fix_wr_4095", Wr, 4095);
    // Wj=0.5, I=4, Q=2 -> pr=1, pj=2
    Wr_in = '0; Wj_in = 13'sd2048; bus.Ix = 4'hC; bus.Qx = 4'hA;
    tick(); tick();
    chk("fix_wj_iy", bus.Iy, 5);
    chk("fix_wj_qy", bus.Qy, 4);
    // Wr=-0.5, I=4, Q=-5 -> pr=-2, pj=floor(-2.5)=-3
    Wr_in = -13'sd2048; Wj_in = '0; bus.Qx = 4'h3;
    tick(); tick();
    chk("fix_neg_iy", bus.Iy, 2);
    chk("fix_floor_qy", bus.Qy, -8);
    // Wr=4095, I=-8 -> pr=-8, -16 saturates to -8
    Wr_in = 13'sd4095; bus.Ix = 4'h0; bus.Qx = 4'h8;
    tick(); tick();
    chk("fix_sat_lo", bus.Iy, -8);
    chk("fix_sat_lo_qy", bus.Qy, 0);

    // Adapt from 0
    bus.in_valid = 1'b0; RESET = 1'b1; op_mode = 2'b01;
    Wr_in = '0; Wj_in = '0;
    tick();
    RESET = 1'b0;
    tick();
    chk("ad_wr0", Wr, 0);
    bus.Ix = 4'hC; bus.Qx = 4'h8; bus.in_valid = 1'b1;
    tick();
    chk("ad_ov0", bus.out_valid, 0);
    tick();
    chk("ad_ov1", bus.out_valid, 1);
    chk("ad_iy_first", bus.Iy, 4);
    chk("ad_wr_first", Wr, -1);
    chk("ad_wj_first", Wj, 0);
    chk("ad_settled_first", settled, 0);
    for (int n = 1; n <= 66; n++) begin
      tick();
      chk("ad_iy", bus.Iy, 3);
      chk("ad_settled", settled, (n >= 64) ? 1 : 0);
    end
    chk("ad_qy", bus.Qy, 0);
    chk("ad_wr", Wr, -1);
    chk("ad_wj", Wj, 0);

    // Freeze: I=7, Wr=-1 -> 7 + floor(-7/4096) = 6
    freeze_iqcomp = 1'b1; bus.Ix = 4'hF;
    tick(); tick(); tick();
    chk("frz_iy", bus.Iy, 6);
    chk("frz_wr", Wr, -1);
    chk("frz_wj", Wj, 0);
    chk("frz_settled", settled, 1);

    // Preset load in mode 11, then adaptation with I=7, Q=3
    bus.in_valid = 1'b0;
    tick(); tick();
    op_mode = 2'b11; freeze_iqcomp = 1'b0; Wr_in = 13'sd100; Wj_in = '0;
    tick();
    chk("pre_wr_load", Wr, 100);
    chk("pre_wj_load", Wj, 0);
    chk("pre_settled", settled, 0);
    bus.Ix = 4'hF; bus.Qx = 4'hB; bus.in_valid = 1'b1;
    tick();
    chk("pre_wr_idle", Wr, 100);
    tick();
    chk("pre_ov", bus.out_valid, 1);
    chk("pre_iy1", bus.Iy, 7);
    chk("pre_qy1", bus.Qy, 2);
    chk("pre_wr1", Wr, 98);
    chk("pre_wj1", Wj, -1);
    tick();
    chk("pre_iy2", bus.Iy, 7);
    chk("pre_qy2", bus.Qy, 2);
    chk("pre_wr2", Wr, 96);
    chk("pre_wj2", Wj, -2);
    chk("pre_settled2", settled, 0);

    // Reset mid-stream
    op_mode = 2'b01;
    tick(); tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0; bus.in_valid = 1'b0; bus.Ix = 4'hF; bus.Qx = 4'h8;
    chk("mrst_wr", Wr, 0);
    chk("mrst_wj", Wj, 0);
    chk("mrst_ov", bus.out_valid, 0);
    chk("mrst_settled", settled, 0);
    chk("mrst_iy", bus.Iy, 0);
    tick();
    chk("mrst_ov_flush", bus.out_valid, 0);
    chk("mrst_wr_idle", Wr, 0);
    bus.in_valid = 1'b1;
    tick();
    chk("mrst_ov_lat1", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    tick();
    chk("mrst_ov_lat2", bus.out_valid, 1);
    chk("mrst_iy_out", bus.Iy, 7);
    chk("mrst_qy_out", bus.Qy, 0);
    chk("mrst_wr_upd", Wr, -3);
    tick();
    chk("mrst_ov_end", bus.out_valid, 0);
    chk("mrst_wr_hold", Wr, -3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
